// File: rtl/flash_ctrl_pkg.sv
// flash_ctrl shared types and constants.
// State encoding, spi cmd_type codes and op_code values.
package flash_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WREN_REQ,
    S_WREN_WAIT,
    S_MAIN_REQ,
    S_MAIN_WAIT,
    S_POLL_REQ,
    S_POLL_WAIT,
    S_FIN
  } state_t;

  localparam logic [2:0] CT_RDID = 3'b000;
  localparam logic [2:0] CT_WREN = 3'b001;
  localparam logic [2:0] CT_SE   = 3'b010;
  localparam logic [2:0] CT_RDSR = 3'b011;
  localparam logic [2:0] CT_PP   = 3'b101;
  localparam logic [2:0] CT_READ = 3'b111;

  localparam logic [1:0] OP_RDID = 2'b00;
  localparam logic [1:0] OP_SE   = 2'b01;
  localparam logic [1:0] OP_PP   = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  function automatic logic op_is_write(
    input logic [1:0] op
  );
    return (op == OP_SE) || (op == OP_PP);
  endfunction

  function automatic logic [2:0] main_ct(
    input logic [1:0] op
  );
    logic [2:0] ct;
    ct = CT_RDID;
    unique case (op)
      OP_RDID: ct = CT_RDID;
      OP_SE:   ct = CT_SE;
      OP_PP:   ct = CT_PP;
      OP_READ: ct = CT_READ;
      default: ct = CT_RDID;
    endcase
    return ct;
  endfunction

endpackage

// File: rtl/flash_ctrl.sv
// flash_ctrl: turns one op request into the
// WREN / main / RDSR-poll sequence for spi.
module flash_ctrl
  import flash_ctrl_pkg::*;
#(
  parameter logic [19:0] POLL_MAX = 20'd1000000,
  parameter logic [7:0]  CMD_WREN = 8'h06,
  parameter logic [7:0]  CMD_SE   = 8'h20,
  parameter logic [7:0]  CMD_PP   = 8'h02,
  parameter logic [7:0]  CMD_READ = 8'h03,
  parameter logic [7:0]  CMD_RDSR = 8'h05,
  parameter logic [7:0]  CMD_RDID = 8'h90
) (
  input  logic        clock25M,
  input  logic        flash_rst,
  input  logic        op_start,
  input  logic [1:0]  op_code,
  input  logic [23:0] op_addr,
  output logic        op_busy,
  output logic        op_done,
  output logic        op_err,
  output logic [7:0]  status_o,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic [7:0]  rd_index,
  output logic [3:0]  spi_cmd_type,
  output logic [7:0]  spi_flash_cmd,
  output logic [23:0] spi_flash_addr,
  input  logic        spi_done,
  input  logic [7:0]  spi_data,
  input  logic        spi_valid
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_code;
  logic [23:0] r_addr;
  logic [19:0] r_poll;
  logic [7:0]  r_idx;
  logic        r_err;
  logic [7:0]  r_status;
  logic [7:0]  r_rd_data;
  logic        r_rd_valid;
  logic [7:0]  r_rd_index;

  logic        w_accept;
  logic        w_strobe;
  logic [2:0]  w_ct;
  logic [7:0]  w_cmd;
  logic [23:0] w_addr;
  logic [7:0]  w_main_cmd;
  logic        w_timeout;
  logic        w_poll_inc;
  logic        w_cap_rd;

  assign w_accept = (r_state == S_IDLE) && op_start;
  assign w_cap_rd = (r_state == S_MAIN_WAIT)
                 && !op_is_write(r_code)
                 && spi_valid;

  // opcode byte for the main command of the latched op
  always_comb begin
    w_main_cmd = CMD_RDID;
    unique case (r_code)
      OP_RDID: w_main_cmd = CMD_RDID;
      OP_SE:   w_main_cmd = CMD_SE;
      OP_PP:   w_main_cmd = CMD_PP;
      OP_READ: w_main_cmd = CMD_READ;
      default: w_main_cmd = CMD_RDID;
    endcase
  end

  // next state and spi request fields; REQ strobes, WAIT holds
  always_comb begin
    w_next     = r_state;
    w_strobe   = 1'b0;
    w_ct       = 3'b000;
    w_cmd      = 8'h00;
    w_addr     = 24'h0;
    w_timeout  = 1'b0;
    w_poll_inc = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (op_start)
          w_next = op_is_write(op_code)
                 ? S_WREN_REQ : S_MAIN_REQ;
      end
      S_WREN_REQ: begin
        w_strobe = 1'b1;
        w_ct     = CT_WREN;
        w_cmd    = CMD_WREN;
        w_addr   = r_addr;
        w_next   = S_WREN_WAIT;
      end
      S_WREN_WAIT: begin
        w_ct   = CT_WREN;
        w_cmd  = CMD_WREN;
        w_addr = r_addr;
        if (spi_done)
          w_next = S_MAIN_REQ;
      end
      S_MAIN_REQ: begin
        w_strobe = 1'b1;
        w_ct     = main_ct(r_code);
        w_cmd    = w_main_cmd;
        w_addr   = r_addr;
        w_next   = S_MAIN_WAIT;
      end
      S_MAIN_WAIT: begin
        w_ct   = main_ct(r_code);
        w_cmd  = w_main_cmd;
        w_addr = r_addr;
        if (spi_done)
          w_next = op_is_write(r_code)
                 ? S_POLL_REQ : S_FIN;
      end
      S_POLL_REQ: begin
        w_strobe = 1'b1;
        w_ct     = CT_RDSR;
        w_cmd    = CMD_RDSR;
        w_addr   = r_addr;
        w_next   = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        w_ct   = CT_RDSR;
        w_cmd  = CMD_RDSR;
        w_addr = r_addr;
        if (spi_done) begin
          if (!r_status[0]) begin
            w_next = S_FIN;
          end else if (r_poll == POLL_MAX - 20'd1) begin
            w_next    = S_FIN;
            w_timeout = 1'b1;
          end else begin
            w_next     = S_POLL_REQ;
            w_poll_inc = 1'b1;
          end
        end
      end
      S_FIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge clock25M) begin
    if (flash_rst)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // op latch, poll counter, error flag and data capture
  always_ff @(posedge clock25M) begin
    if (flash_rst) begin
      r_code     <= OP_RDID;
      r_addr     <= 24'h0;
      r_poll     <= 20'h0;
      r_idx      <= 8'h00;
      r_err      <= 1'b0;
      r_status   <= 8'h00;
      r_rd_data  <= 8'h00;
      r_rd_valid <= 1'b0;
      r_rd_index <= 8'h00;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_accept) begin
        r_code     <= op_code;
        r_addr     <= op_addr;
        r_poll     <= 20'h0;
        r_idx      <= 8'h00;
        r_err      <= 1'b0;
        r_rd_index <= 8'h00;
      end
      if (w_poll_inc)
        r_poll <= r_poll + 20'd1;
      if (w_timeout)
        r_err <= 1'b1;
      if ((r_state == S_POLL_WAIT) && spi_valid)
        r_status <= spi_data;
      if (w_cap_rd) begin
        r_rd_data  <= spi_data;
        r_rd_valid <= 1'b1;
        r_rd_index <= r_idx;
        if (r_idx != 8'hFF)
          r_idx <= r_idx + 8'd1;
      end
    end
  end

  assign op_busy        = (r_state != S_IDLE);
  assign op_done        = (r_state == S_FIN);
  assign op_err         = r_err;
  assign status_o       = r_status;
  assign rd_data        = r_rd_data;
  assign rd_valid       = r_rd_valid;
  assign rd_index       = r_rd_index;
  assign spi_cmd_type   = {w_strobe, w_ct};
  assign spi_flash_cmd  = w_cmd;
  assign spi_flash_addr = w_addr;

endmodule

// File: tb/tb_flash_ctrl.sv
// tb_flash_ctrl: flash_ctrl against a behavioural
// spi + flash responder and an op-level model.
module tb_flash_ctrl;

  localparam logic [19:0] PMAX = 20'd8;

  logic        clk;
  logic        flash_rst;
  logic        op_start;
  logic [1:0]  op_code;
  logic [23:0] op_addr;
  logic        op_busy;
  logic        op_done;
  logic        op_err;
  logic [7:0]  status_o;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic [7:0]  rd_index;
  logic [3:0]  spi_cmd_type;
  logic [7:0]  spi_flash_cmd;
  logic [23:0] spi_flash_addr;
  logic        spi_done;
  logic [7:0]  spi_data;
  logic        spi_valid;

  flash_ctrl #(.POLL_MAX(PMAX)) dut (
    .clock25M       (clk),
    .flash_rst      (flash_rst),
    .op_start       (op_start),
    .op_code        (op_code),
    .op_addr        (op_addr),
    .op_busy        (op_busy),
    .op_done        (op_done),
    .op_err         (op_err),
    .status_o       (status_o),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_index       (rd_index),
    .spi_cmd_type   (spi_cmd_type),
    .spi_flash_cmd  (spi_flash_cmd),
    .spi_flash_addr (spi_flash_addr),
    .spi_done       (spi_done),
    .spi_data       (spi_data),
    .spi_valid      (spi_valid)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  int n_tot = 0;
  int n_pass = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  nm, act, exp);
  endtask

  typedef struct packed {
    logic [3:0]  ct;
    logic [7:0]  cmd;
    logic [23:0] addr;
  } txn_t;

  txn_t log_q[$];

  always @(negedge clk) begin
    txn_t t;
    if (!flash_rst && spi_cmd_type[3] === 1'b1) begin
      t.ct   = spi_cmd_type;
      t.cmd  = spi_flash_cmd;
      t.addr = spi_flash_addr;
      log_q.push_back(t);
    end
  end

  // responder: per-cycle script of {done,valid,data}
  logic [9:0] rq[$];
  int cfg_busy = 0;
  int busy_left = 0;
  bit all_busy = 0;

  task automatic build(input logic [2:0] ct);
    logic [7:0] st;
    logic [7:0] b;
    case (ct)
      3'b001, 3'b010, 3'b101: begin
        if (ct != 3'b001) busy_left = cfg_busy;
        rq.push_back(10'h000);
        rq.push_back(10'h000);
        rq.push_back(10'h200);
      end
      3'b011: begin
        st = (all_busy || busy_left > 0) ? 8'h03 : 8'h00;
        if (busy_left > 0) busy_left--;
        rq.push_back(10'h000);
        rq.push_back({2'b01, st});
        rq.push_back(10'h000);
        rq.push_back(10'h200);
      end
      3'b000: begin
        rq.push_back({2'b01, 8'hEF});
        rq.push_back(10'h000);
        rq.push_back({2'b01, 8'h17});
        rq.push_back(10'h000);
        rq.push_back(10'h200);
      end
      3'b111: begin
        for (int i = 0; i < 256; i++) begin
          b = i[7:0] ^ 8'h5A;
          rq.push_back({2'b01, b});
          if (i % 3 == 0) rq.push_back(10'h000);
        end
        rq.push_back(10'h000);
        rq.push_back(10'h200);
      end
      default: rq.push_back(10'h200);
    endcase
  endtask

  always @(negedge clk) begin
    logic [9:0] e;
    if (flash_rst) begin
      rq.delete();
      busy_left = 0;
      spi_done  = 1'b0;
      spi_valid = 1'b0;
      spi_data  = 8'h00;
    end else if (rq.size() > 0) begin
      e = rq.pop_front();
      spi_done  = e[9];
      spi_valid = e[8];
      spi_data  = e[7:0];
    end else begin
      spi_done  = 1'b0;
      spi_valid = 1'b0;
      if (spi_cmd_type[3] === 1'b1)
        build(spi_cmd_type[2:0]);
    end
  end

  // op-level model state
  logic [15:0] exp_rd[$];
  logic        exp_err = 1'b0;
  bit          exp_chk_st = 0;
  logic [7:0]  exp_status = 8'h00;
  logic [1:0]  exp_code = 2'b00;
  logic [23:0] exp_addr = 24'h0;
  int          exp_polls = 0;
  int          done_cnt = 0;
  logic [7:0]  obs_data [256];

  // compare process
  always @(posedge clk) begin
    logic [15:0] p;
    #1;
    if (!flash_rst) begin
      if (rd_valid) begin
        if (exp_rd.size() == 0) begin
          n_tot++;
          $display("FAIL rd_extra: got idx %0h data %0h, expected none",
                   rd_index, rd_data);
        end else begin
          p = exp_rd.pop_front();
          chk("rd_index", {24'h0, rd_index}, {24'h0, p[15:8]});
          chk("rd_data", {24'h0, rd_data}, {24'h0, p[7:0]});
          obs_data[rd_index] = rd_data;
        end
      end
      if (op_done) begin
        done_cnt++;
        chk("op_err", {31'h0, op_err}, {31'h0, exp_err});
        if (exp_chk_st)
          chk("status_o", {24'h0, status_o}, {24'h0, exp_status});
      end
    end
  end

  task automatic start_op(input logic [1:0] code,
                          input logic [23:0] addr,
                          input int nbusy,
                          input bit allb);
    logic [7:0] b;
    log_q.delete();
    exp_rd.delete();
    cfg_busy  = nbusy;
    all_busy  = allb;
    done_cnt  = 0;
    exp_code  = code;
    exp_addr  = addr;
    exp_polls = 0;
    if (code == 2'b01 || code == 2'b10) begin
      exp_chk_st = 1;
      if (allb || nbusy >= int'(PMAX)) begin
        exp_polls  = int'(PMAX);
        exp_err    = 1'b1;
        exp_status = 8'h03;
      end else begin
        exp_polls  = nbusy + 1;
        exp_err    = 1'b0;
        exp_status = 8'h00;
      end
    end else begin
      exp_chk_st = 0;
      exp_err    = 1'b0;
      if (code == 2'b00) begin
        exp_rd.push_back({8'd0, 8'hEF});
        exp_rd.push_back({8'd1, 8'h17});
      end else begin
        for (int i = 0; i < 256; i++) begin
          b = i[7:0] ^ 8'h5A;
          exp_rd.push_back({i[7:0], b});
        end
      end
    end
    @(negedge clk);
    chk("idle_busy", {31'h0, op_busy}, 32'h0);
    op_start = 1'b1;
    op_code  = code;
    op_addr  = addr;
    @(posedge clk);
    #1;
    chk("busy_rise", {31'h0, op_busy}, 32'h1);
    chk("req_strobe", {31'h0, spi_cmd_type[3]}, 32'h1);
    @(negedge clk);
    op_start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (op_done !== 1'b1 && n < 4000);
    if (op_done !== 1'b1) begin
      n_tot++;
      $display("FAIL op_done_timeout: got none, expected pulse");
    end
  endtask

  task automatic check_seq();
    txn_t e[$];
    txn_t t;
    int   m;
    bit   wr;
    wr = (exp_code == 2'b01 || exp_code == 2'b10);
    if (wr) begin
      t = '{4'h9, 8'h06, exp_addr};
      e.push_back(t);
      t = (exp_code == 2'b01) ? '{4'hA, 8'h20, exp_addr}
                              : '{4'hD, 8'h02, exp_addr};
      e.push_back(t);
      for (int i = 0; i < exp_polls; i++) begin
        t = '{4'hB, 8'h05, exp_addr};
        e.push_back(t);
      end
    end else begin
      t = (exp_code == 2'b00) ? '{4'h8, 8'h90, exp_addr}
                              : '{4'hF, 8'h03, exp_addr};
      e.push_back(t);
    end
    chk("n_txn", log_q.size(), e.size());
    m = (log_q.size() < e.size()) ? log_q.size() : e.size();
    for (int i = 0; i < m; i++) begin
      chk("txn_type", {28'h0, log_q[i].ct}, {28'h0, e[i].ct});
      chk("txn_cmd", {24'h0, log_q[i].cmd}, {24'h0, e[i].cmd});
      if (i == (wr ? 1 : 0))
        chk("txn_addr", {8'h0, log_q[i].addr}, {8'h0, e[i].addr});
    end
  endtask

  task automatic settle_and_check();
    repeat (4) @(negedge clk);
    chk("idle_after", {31'h0, op_busy}, 32'h0);
    chk("done_cnt", done_cnt, 1);
    chk("rd_left", exp_rd.size(), 0);
    check_seq();
  endtask

  task automatic reset_checks();
    chk("rst_busy", {31'h0, op_busy}, 32'h0);
    chk("rst_done", {31'h0, op_done}, 32'h0);
    chk("rst_err", {31'h0, op_err}, 32'h0);
    chk("rst_rdv", {31'h0, rd_valid}, 32'h0);
    chk("rst_status", {24'h0, status_o}, 32'h0);
    chk("rst_rddata", {24'h0, rd_data}, 32'h0);
    chk("rst_rdidx", {24'h0, rd_index}, 32'h0);
    chk("rst_ct", {28'h0, spi_cmd_type}, 32'h0);
    chk("rst_cmd", {24'h0, spi_flash_cmd}, 32'h0);
    chk("rst_addr", {8'h0, spi_flash_addr}, 32'h0);
  endtask

  initial begin
    #(40 * 60000);
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    flash_rst = 1'b1;
    op_start  = 1'b0;
    op_code   = 2'b00;
    op_addr   = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    flash_rst = 1'b0;

    start_op(2'b00, 24'h000000, 0, 0);
    wait_done();
    settle_and_check();
    chk("rdid_b0", {24'h0, obs_data[0]}, 32'hEF);
    chk("rdid_b1", {24'h0, obs_data[1]}, 32'h17);

    start_op(2'b11, 24'h012300, 0, 0);
    wait_done();
    settle_and_check();
    chk("read_last_idx", {24'h0, rd_index}, 32'hFF);
    chk("read_last_dat", {24'h0, rd_data}, 32'hA5);
    chk("read_mid_dat", {24'h0, obs_data[128]}, 32'hDA);

    start_op(2'b01, 24'h010000, 5, 0);
    wait_done();
    settle_and_check();
    chk("se_status", {24'h0, status_o}, 32'h00);
    chk("se_err", {31'h0, op_err}, 32'h0);

    start_op(2'b10, 24'h000100, 0, 1);
    wait_done();
    settle_and_check();
    chk("pp_err_held", {31'h0, op_err}, 32'h1);
    chk("pp_status", {24'h0, status_o}, 32'h03);

    start_op(2'b00, 24'h000000, 0, 0);
    chk("err_cleared", {31'h0, op_err}, 32'h0);
    wait_done();
    settle_and_check();

    start_op(2'b11, 24'h012300, 0, 0);
    repeat (30) @(negedge clk);
    op_start = 1'b1;
    op_code  = 2'b00;
    @(negedge clk);
    op_start = 1'b0;
    wait_done();
    op_start = 1'b1;
    op_code  = 2'b01;
    @(posedge clk);
    #1;
    op_start = 1'b0;
    chk("fin_start_ign", {31'h0, op_busy}, 32'h0);
    repeat (6) @(negedge clk);
    settle_and_check();

    start_op(2'b01, 24'h020000, 0, 1);
    n = 0;
    while (log_q.size() < 3 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (log_q.size() < 3) begin
      n_tot++;
      $display("FAIL poll_reach: got %0d txns, expected 3",
               log_q.size());
    end
    @(negedge clk);
    flash_rst = 1'b1;
    @(posedge clk);
    #1;
    reset_checks();
    @(negedge clk);
    flash_rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_done", done_cnt, 0);

    start_op(2'b00, 24'h000000, 0, 0);
    wait_done();
    settle_and_check();
    chk("rdid2_b0", {24'h0, obs_data[0]}, 32'hEF);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
